// File: rtl/slot_request_queue.sv
// ---------------------------------------------------------------------------
// slot_request_queue
//
// Slot-addressed request buffer for the CCI-P transmit path. A push stores one
// request word in a free slot and reports the slot id. A later pop by slot id
// reads the word back and returns the slot to an internal free-slot FIFO.
// The free-slot FIFO is filled by an explicit initialization sequence
// (ids 0..N-1 in ascending order) before any push or pop is accepted.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous active-low reset
//   push_en_in        push request, one word per cycle
//   push_data_in      word to store
//   push_slot_id_out  slot allocated to the accepted push (held otherwise)
//   push_done_out     one-cycle pulse, push accepted
//   pop_en_in         pop request
//   pop_slot_id_in    slot to read and free
//   pop_data_out      registered word read from the popped slot (held otherwise)
//   initialize        start free-list fill (level, sampled in IDLE)
//   initialized       high once the free list is full, until reset
//   error             sticky error flag (overflow, bad pop, access before ready)
// ---------------------------------------------------------------------------
module slot_request_queue #(
    parameter int DATA_WIDTH = 64,
    parameter int LSIZE      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_en_in,
    input  logic [DATA_WIDTH-1:0] push_data_in,
    output logic [LSIZE-1:0]      push_slot_id_out,
    output logic                  push_done_out,
    input  logic                  pop_en_in,
    input  logic [LSIZE-1:0]      pop_slot_id_in,
    output logic [DATA_WIDTH-1:0] pop_data_out,
    input  logic                  initialize,
    output logic                  initialized,
    output logic                  error
);

    localparam int N = 1 << LSIZE;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        READY
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [N];
    logic [LSIZE-1:0]      free_fifo [N];
    logic [LSIZE-1:0]      head_q, tail_q;
    logic [LSIZE:0]        count_q;
    logic [N-1:0]          alloc_q;

    logic             fifo_wr;
    logic [LSIZE-1:0] fifo_wr_id;
    logic             push_ok;
    logic             pop_rd;
    logic             pop_free;
    logic             err_set;
    logic [LSIZE-1:0] alloc_id;

    // The slot handed out by a push is always the current head of the free FIFO.
    assign alloc_id = free_fifo[head_q];

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned; a missing default would infer a latch.
    always_comb begin
        state_d    = state_q;
        fifo_wr    = 1'b0;
        fifo_wr_id = tail_q;
        push_ok    = 1'b0;
        pop_rd     = 1'b0;
        pop_free   = 1'b0;
        err_set    = 1'b0;

        case (state_q)
            IDLE: begin
                // tail_q is 0 here, so the first id written is 0.
                if (initialize) begin
                    fifo_wr = 1'b1;
                    state_d = INIT;
                end
            end
            INIT: begin
                // During the fill the tail pointer equals the next id to write.
                fifo_wr = 1'b1;
                if (tail_q == LSIZE'(N - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                // A slot freed this cycle lands at the tail, so it cannot
                // rescue a push that finds the FIFO empty.
                push_ok    = push_en_in && (count_q != '0);
                pop_rd     = pop_en_in;
                pop_free   = pop_en_in && alloc_q[pop_slot_id_in];
                fifo_wr    = pop_free;
                fifo_wr_id = pop_slot_id_in;
                err_set    = (push_en_in && (count_q == '0)) ||
                             (pop_en_in && !alloc_q[pop_slot_id_in]);
            end
            default: state_d = IDLE;
        endcase

        if (state_q != READY && (push_en_in || pop_en_in)) begin
            err_set = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            alloc_q          <= '0;
            initialized      <= 1'b0;
            error            <= 1'b0;
            push_done_out    <= 1'b0;
            push_slot_id_out <= '0;
            pop_data_out     <= '0;
        end else begin
            state_q       <= state_d;
            initialized   <= (state_d == READY);
            push_done_out <= push_ok;
            count_q       <= count_q + (LSIZE + 1)'(fifo_wr) - (LSIZE + 1)'(push_ok);

            if (err_set) begin
                error <= 1'b1;
            end
            if (fifo_wr) begin
                tail_q <= tail_q + 1'b1;
            end
            if (push_ok) begin
                head_q           <= head_q + 1'b1;
                push_slot_id_out <= alloc_id;
            end

            // A pushed slot is free and a freed slot is allocated, so the two
            // bitmap updates never target the same bit.
            if (pop_free) begin
                alloc_q[pop_slot_id_in] <= 1'b0;
            end
            if (push_ok) begin
                alloc_q[alloc_id] <= 1'b1;
            end
            if (pop_rd) begin
                pop_data_out <= mem[pop_slot_id_in];
            end
        end
    end

    // NOTE: storage arrays carry no reset; their contents are only meaningful
    // once written, and resetting them would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[alloc_id] <= push_data_in;
        end
        if (fifo_wr) begin
            free_fifo[tail_q] <= fifo_wr_id;
        end
    end

endmodule

// File: tb/tb_slot_request_queue.sv
// ---------------------------------------------------------------------------
// tb_slot_request_queue
//
// Self-checking bench for slot_request_queue (DATA_WIDTH=64, LSIZE=3).
// A vector table covers initialization, a full fill, overflow and a pop; hand
// sequences cover slot reuse, bad pops, same-cycle push/pop, reset during the
// fill and access before ready.
// ---------------------------------------------------------------------------
module tb_slot_request_queue;

    localparam int DW = 64;
    localparam int LS = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          push_en_in;
    logic [DW-1:0] push_data_in;
    logic [LS-1:0] push_slot_id_out;
    logic          push_done_out;
    logic          pop_en_in;
    logic [LS-1:0] pop_slot_id_in;
    logic [DW-1:0] pop_data_out;
    logic          initialize;
    logic          initialized;
    logic          error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slot_request_queue #(.DATA_WIDTH(DW), .LSIZE(LS)) dut (
        .clk              (clk),
        .reset            (reset),
        .push_en_in       (push_en_in),
        .push_data_in     (push_data_in),
        .push_slot_id_out (push_slot_id_out),
        .push_done_out    (push_done_out),
        .pop_en_in        (pop_en_in),
        .pop_slot_id_in   (pop_slot_id_in),
        .pop_data_out     (pop_data_out),
        .initialize       (initialize),
        .initialized      (initialized),
        .error            (error)
    );

    typedef struct {
        logic          push_en;
        logic [DW-1:0] push_data;
        logic          pop_en;
        logic [LS-1:0] pop_id;
        logic          init;
        logic          exp_done;
        logic [LS-1:0] exp_slot;
        logic [DW-1:0] exp_pop;
        logic          exp_initd;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] actual,
                         input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock edge with the given inputs; outputs are sampled 1 time unit
    // after the edge and inputs return to idle.
    task automatic cyc(input logic pe, input logic [DW-1:0] pd, input logic po,
                       input logic [LS-1:0] pid, input logic ini);
        push_en_in     = pe;
        push_data_in   = pd;
        pop_en_in      = po;
        pop_slot_id_in = pid;
        initialize     = ini;
        @(posedge clk);
        #1;
        push_en_in = 1'b0;
        pop_en_in  = 1'b0;
        initialize = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("reset_initialized", initialized, 0);
        check("reset_error", error, 0);
        check("reset_push_done", push_done_out, 0);
        check("reset_slot", push_slot_id_out, 0);
        check("reset_pop_data", pop_data_out, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // initialize sampled at the first edge; initialized rises after edge 8.
    task automatic do_init();
        for (int e = 1; e <= 8; e++) begin
            cyc(1'b0, '0, 1'b0, '0, e == 1);
            check($sformatf("init_edge%0d", e), initialized, (e == 8) ? 1 : 0);
        end
    endtask

    task automatic push_ok(input logic [DW-1:0] d, input logic [LS-1:0] slot);
        cyc(1'b1, d, 1'b0, '0, 1'b0);
        check("push_done", push_done_out, 1);
        check("push_slot", push_slot_id_out, slot);
    endtask

    task automatic pop_exp(input logic [LS-1:0] id, input logic [DW-1:0] d);
        cyc(1'b0, '0, 1'b1, id, 1'b0);
        check($sformatf("pop_slot%0d", id), pop_data_out, d);
        check("pop_no_done", push_done_out, 0);
    endtask

    initial begin
        reset          = 1'b0;
        push_en_in     = 1'b0;
        push_data_in   = '0;
        pop_en_in      = 1'b0;
        pop_slot_id_in = '0;
        initialize     = 1'b0;

        // Table: init (8 edges), 8 pushes, overflow push, pop of slot 3.
        for (int e = 1; e <= 8; e++) begin
            vecs.push_back('{1'b0, 64'h0, 1'b0, 3'd0, e == 1,
                             1'b0, 3'd0, 64'h0, e == 8, 1'b0});
        end
        for (int i = 0; i < 8; i++) begin
            vecs.push_back('{1'b1, 64'h10 + 64'(i), 1'b0, 3'd0, 1'b0,
                             1'b1, 3'(i), 64'h0, 1'b1, 1'b0});
        end
        vecs.push_back('{1'b1, 64'h18, 1'b0, 3'd0, 1'b0,
                         1'b0, 3'd7, 64'h0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 64'h0, 1'b1, 3'd3, 1'b0,
                         1'b0, 3'd7, 64'h13, 1'b1, 1'b1});

        #12;
        do_reset();
        foreach (vecs[k]) begin
            cyc(vecs[k].push_en, vecs[k].push_data, vecs[k].pop_en,
                vecs[k].pop_id, vecs[k].init);
            check($sformatf("v%0d_done", k), push_done_out, vecs[k].exp_done);
            check($sformatf("v%0d_slot", k), push_slot_id_out, vecs[k].exp_slot);
            check($sformatf("v%0d_pop", k), pop_data_out, vecs[k].exp_pop);
            check($sformatf("v%0d_initd", k), initialized, vecs[k].exp_initd);
            check($sformatf("v%0d_err", k), error, vecs[k].exp_err);
        end

        // Slot reuse: freed slot 1 is allocated after slots 3..7.
        do_reset();
        do_init();
        push_ok(64'h10, 3'd0);
        push_ok(64'h11, 3'd1);
        push_ok(64'h12, 3'd2);
        pop_exp(3'd1, 64'h11);
        for (int i = 3; i < 8; i++) push_ok(64'h10 + 64'(i), 3'(i));
        push_ok(64'hAA, 3'd1);
        pop_exp(3'd1, 64'hAA);
        check("reuse_err", error, 0);

        // Pop of an unallocated slot: data still read (memory survives reset),
        // error set, free count unchanged (still exactly 8 pushes fit).
        do_reset();
        do_init();
        pop_exp(3'd5, 64'h15);
        check("badpop_err", error, 1);
        for (int i = 0; i < 8; i++) push_ok(64'h30 + 64'(i), 3'(i));
        cyc(1'b1, 64'h38, 1'b0, '0, 1'b0);
        check("badpop_overflow_done", push_done_out, 0);

        // Same-cycle push and pop with the free FIFO empty.
        do_reset();
        do_init();
        for (int i = 0; i < 8; i++) push_ok(64'h20 + 64'(i), 3'(i));
        check("full_err", error, 0);
        cyc(1'b1, 64'h55, 1'b1, 3'd0, 1'b0);
        check("pp_done", push_done_out, 0);
        check("pp_err", error, 1);
        check("pp_pop", pop_data_out, 64'h20);
        push_ok(64'h66, 3'd0);
        pop_exp(3'd0, 64'h66);

        // Reset during the fill, then a clean re-initialization.
        do_reset();
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0, '0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("midinit_initialized", initialized, 0);
        check("midinit_err", error, 0);
        @(negedge clk);
        reset = 1'b1;
        do_init();
        for (int i = 0; i < 8; i++) push_ok(64'h40 + 64'(i), 3'(i));
        cyc(1'b1, 64'h48, 1'b0, '0, 1'b0);
        check("reinit_overflow_done", push_done_out, 0);
        check("reinit_overflow_err", error, 1);

        // Access before ready is ignored and flagged.
        do_reset();
        cyc(1'b1, 64'h77, 1'b0, '0, 1'b0);
        check("idle_push_done", push_done_out, 0);
        check("idle_push_err", error, 1);
        do_reset();
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1, 3'd0, 1'b0);
        check("init_pop_data", pop_data_out, 0);
        check("init_pop_err", error, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
